// File: rtl/nabp_shift_sequencer.sv
// Shift sequencer for the filter mapper. It runs a fill (pipeline priming) phase and then
// a shift phase, gated by state_control kicks and by mapper back-pressure.
module nabp_shift_sequencer #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned MAX_FILL  = 16,
  parameter int unsigned MAX_SHIFT = 256
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               sc_fill_kick,
  input  logic                               sc_shift_kick,
  input  logic                               sc_abort,
  input  logic [$clog2(MAX_FILL+1)-1:0]      cfg_fill_len,
  input  logic [$clog2(MAX_SHIFT+1)-1:0]     cfg_shift_len,
  input  logic [NUM_CH-1:0]                  cfg_ch_mask,
  input  logic                               fm_ready,
  output logic                               sc_fill_done,
  output logic                               sc_shift_done,
  output logic                               sc_busy,
  output logic                               sc_kick_err,
  output logic [NUM_CH-1:0]                  fm_shift_enable
);

  localparam int unsigned FILL_W  = $clog2(MAX_FILL + 1);
  localparam int unsigned SHIFT_W = $clog2(MAX_SHIFT + 1);

  localparam logic [1:0] S_READY     = 2'd0;
  localparam logic [1:0] S_FILL      = 2'd1;
  localparam logic [1:0] S_FILL_DONE = 2'd2;
  localparam logic [1:0] S_SHIFT     = 2'd3;

  logic [1:0]         state, state_nxt;
  logic [FILL_W-1:0]  fill_cnt, fill_cnt_nxt;
  logic [SHIFT_W-1:0] shift_cnt, shift_cnt_nxt;
  logic [NUM_CH-1:0]  mask, mask_nxt;
  logic               fill_done_nxt, shift_done_nxt, kick_err_nxt;
  logic               abort_act;

  // Zero-length requests still run one cycle; oversize requests saturate at the maximum.
  function automatic logic [FILL_W-1:0] clamp_fill(input logic [FILL_W-1:0] len);
    if (len == '0) return FILL_W'(1);
    if (len > FILL_W'(MAX_FILL)) return FILL_W'(MAX_FILL);
    return len;
  endfunction

  function automatic logic [SHIFT_W-1:0] clamp_shift(input logic [SHIFT_W-1:0] len);
    if (len == '0) return SHIFT_W'(1);
    if (len > SHIFT_W'(MAX_SHIFT)) return SHIFT_W'(MAX_SHIFT);
    return len;
  endfunction

  assign sc_busy = (state != S_READY);

  always_comb begin
    state_nxt       = state;
    fill_cnt_nxt    = fill_cnt;
    shift_cnt_nxt   = shift_cnt;
    mask_nxt        = mask;
    fill_done_nxt   = 1'b0;
    shift_done_nxt  = 1'b0;
    fm_shift_enable = '0;
    kick_err_nxt    = sc_kick_err
                    | (sc_fill_kick  && (state != S_READY))
                    | (sc_shift_kick && (state != S_FILL_DONE));
    abort_act       = sc_abort && (state != S_READY);

    if (abort_act) begin
      // Abandon silently: no done pulse, enables already held low above.
      state_nxt     = S_READY;
      fill_cnt_nxt  = '0;
      shift_cnt_nxt = '0;
    end else begin
      case (state)
        S_READY: begin
          if (sc_fill_kick) begin
            state_nxt    = S_FILL;
            fill_cnt_nxt = clamp_fill(cfg_fill_len);
            mask_nxt     = cfg_ch_mask;
          end
        end
        S_FILL: begin
          fm_shift_enable = mask;
          fill_cnt_nxt    = fill_cnt - FILL_W'(1);
          if (fill_cnt == FILL_W'(1)) begin
            state_nxt     = S_FILL_DONE;
            fill_done_nxt = 1'b1;
          end
        end
        S_FILL_DONE: begin
          if (sc_shift_kick) begin
            state_nxt     = S_SHIFT;
            shift_cnt_nxt = clamp_shift(cfg_shift_len);
          end
        end
        S_SHIFT: begin
          if (fm_ready) begin
            fm_shift_enable = mask;
            shift_cnt_nxt   = shift_cnt - SHIFT_W'(1);
            if (shift_cnt == SHIFT_W'(1)) begin
              state_nxt      = S_READY;
              shift_done_nxt = 1'b1;
            end
          end
        end
        default: state_nxt = S_READY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= S_READY;
      fill_cnt      <= '0;
      shift_cnt     <= '0;
      mask          <= '0;
      sc_fill_done  <= 1'b0;
      sc_shift_done <= 1'b0;
      sc_kick_err   <= 1'b0;
    end else begin
      state         <= state_nxt;
      fill_cnt      <= fill_cnt_nxt;
      shift_cnt     <= shift_cnt_nxt;
      mask          <= mask_nxt;
      sc_fill_done  <= fill_done_nxt;
      sc_shift_done <= shift_done_nxt;
      sc_kick_err   <= kick_err_nxt;
    end
  end

endmodule

// File: tb/tb_nabp_shift_sequencer.sv
// Bench for nabp_shift_sequencer: directed and randomized fill/shift sequences checked
// against transaction-level expectations (clamped lengths, beat counts, pulse timing).
module tb_nabp_shift_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       sc_fill_kick, sc_shift_kick, sc_abort;
  logic [4:0] cfg_fill_len;
  logic [8:0] cfg_shift_len;
  logic [3:0] cfg_ch_mask;
  logic       fm_ready;
  logic       sc_fill_done, sc_shift_done, sc_busy, sc_kick_err;
  logic [3:0] fm_shift_enable;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [3:0] cur_mask;
  int         pat[$];

  nabp_shift_sequencer #(.NUM_CH(4), .MAX_FILL(16), .MAX_SHIFT(256)) dut (
    .clk(clk), .reset_n(reset_n),
    .sc_fill_kick(sc_fill_kick), .sc_shift_kick(sc_shift_kick), .sc_abort(sc_abort),
    .cfg_fill_len(cfg_fill_len), .cfg_shift_len(cfg_shift_len), .cfg_ch_mask(cfg_ch_mask),
    .fm_ready(fm_ready),
    .sc_fill_done(sc_fill_done), .sc_shift_done(sc_shift_done), .sc_busy(sc_busy),
    .sc_kick_err(sc_kick_err), .fm_shift_enable(fm_shift_enable)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  function automatic int clamp_len(input int len, input int max);
    if (len == 0) return 1;
    if (len > max) return max;
    return len;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge in READY; returns in the first FILL_DONE cycle.
  task automatic run_fill(input int len, input logic [3:0] m);
    int n;
    n = clamp_len(len, 16);
    cur_mask = m;
    sc_fill_kick = 1'b1; cfg_fill_len = 5'(len); cfg_ch_mask = m;
    #1 chk("kick_cycle_en", 32'(fm_shift_enable), 32'h0);
    @(negedge clk);
    sc_fill_kick = 1'b0;
    for (int i = 0; i < n; i++) begin
      fm_ready = 1'($urandom_range(0, 1));
      #1;
      chk("fill_en", 32'(fm_shift_enable), 32'(m));
      chk("fill_busy", 32'(sc_busy), 32'h1);
      chk("fill_done_early", 32'(sc_fill_done), 32'h0);
      @(negedge clk);
    end
    #1;
    chk("fill_done_pulse", 32'(sc_fill_done), 32'h1);
    chk("fill_done_en", 32'(fm_shift_enable), 32'h0);
  endtask

  // Called in the first FILL_DONE cycle; returns in the READY cycle carrying sc_shift_done.
  task automatic run_shift(input int len, input int gap);
    int n, beats, cyc;
    logic r;
    n = clamp_len(len, 256);
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      #1;
      chk("fd_hold_pulse", 32'(sc_fill_done), 32'h0);
      chk("fd_hold_en", 32'(fm_shift_enable), 32'h0);
      chk("fd_hold_busy", 32'(sc_busy), 32'h1);
    end
    sc_shift_kick = 1'b1; cfg_shift_len = 9'(len);
    @(negedge clk);
    sc_shift_kick = 1'b0;
    beats = 0; cyc = 0;
    while (beats < n && cyc < 4000) begin
      if (pat.size() > 0) r = 1'(pat.pop_front());
      else r = ($urandom_range(0, 9) < 6);
      fm_ready = r;
      #1;
      chk("shift_en", 32'(fm_shift_enable), r ? 32'(cur_mask) : 32'h0);
      chk("shift_done_early", 32'(sc_shift_done), 32'h0);
      if (r) beats++;
      cyc++;
      @(negedge clk);
    end
    chk("shift_beats", 32'(beats), 32'(n));
    fm_ready = 1'($urandom_range(0, 1));
    #1;
    chk("shift_done_pulse", 32'(sc_shift_done), 32'h1);
    chk("shift_done_busy", 32'(sc_busy), 32'h0);
    chk("shift_done_en", 32'(fm_shift_enable), 32'h0);
  endtask

  initial begin
    reset_n = 1'b0; sc_fill_kick = 1'b0; sc_shift_kick = 1'b0; sc_abort = 1'b0;
    cfg_fill_len = '0; cfg_shift_len = '0; cfg_ch_mask = '0; fm_ready = 1'b0;
    cur_mask = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", 32'(sc_busy), 32'h0);
    chk("rst_en", 32'(fm_shift_enable), 32'h0);
    chk("rst_fdone", 32'(sc_fill_done), 32'h0);
    chk("rst_sdone", 32'(sc_shift_done), 32'h0);
    chk("rst_err", 32'(sc_kick_err), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Basic sequence, then fm_ready pattern 1,0,0,1,1,0,1,1 with back-to-back fill kick.
    @(negedge clk);
    run_fill(3, 4'b1111);
    pat = '{1, 1, 1, 1, 1};
    run_shift(5, 0);
    run_fill(2, 4'b0101);
    pat = '{1, 0, 0, 1, 1, 0, 1, 1};
    run_shift(5, 1);

    // Length clamping at both ends, and an all-zero mask.
    run_fill(0, 4'b0011);
    run_shift(0, 0);
    run_fill(31, 4'b1000);
    run_shift(300, 2);
    run_fill(4, 4'b0000);
    run_shift(7, 0);

    // Abort on the second shift beat.
    run_fill(2, 4'b1010);
    sc_shift_kick = 1'b1; cfg_shift_len = 9'd6;
    @(negedge clk);
    sc_shift_kick = 1'b0; fm_ready = 1'b1;
    #1 chk("abort_beat1_en", 32'(fm_shift_enable), 32'ha);
    @(negedge clk);
    sc_abort = 1'b1; fm_ready = 1'b1;
    #1 chk("abort_cycle_en", 32'(fm_shift_enable), 32'h0);
    @(negedge clk);
    sc_abort = 1'b0;
    #1;
    chk("abort_busy", 32'(sc_busy), 32'h0);
    chk("abort_no_sdone", 32'(sc_shift_done), 32'h0);
    chk("abort_err", 32'(sc_kick_err), 32'h0);
    @(negedge clk);
    #1 chk("abort_no_sdone2", 32'(sc_shift_done), 32'h0);
    @(negedge clk);
    run_fill(3, 4'b1111);
    run_shift(4, 0);

    // Illegal fill kick during FILL: flagged, sequence unaffected, flag sticky.
    sc_fill_kick = 1'b1; cfg_fill_len = 5'd4; cfg_ch_mask = 4'b0110; cur_mask = 4'b0110;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      sc_fill_kick = (i == 1);
      if (i == 1) begin cfg_fill_len = 5'd1; cfg_ch_mask = 4'b1001; end
      #1;
      chk("illegal_fill_en", 32'(fm_shift_enable), 32'h6);
      chk("illegal_fill_err", 32'(sc_kick_err), (i >= 2) ? 32'h1 : 32'h0);
      @(negedge clk);
    end
    sc_fill_kick = 1'b0;
    #1 chk("illegal_fill_fdone", 32'(sc_fill_done), 32'h1);
    run_shift(3, 0);
    chk("err_sticky", 32'(sc_kick_err), 32'h1);

    // Synchronous reset mid-SHIFT clears everything; back-to-back runs afterwards.
    @(negedge clk);
    run_fill(2, 4'b1111);
    sc_shift_kick = 1'b1; cfg_shift_len = 9'd10;
    @(negedge clk);
    sc_shift_kick = 1'b0; fm_ready = 1'b1;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("midrst_busy", 32'(sc_busy), 32'h0);
    chk("midrst_en", 32'(fm_shift_enable), 32'h0);
    chk("midrst_err", 32'(sc_kick_err), 32'h0);
    chk("midrst_sdone", 32'(sc_shift_done), 32'h0);
    @(negedge clk);
    run_fill(1, 4'b0011);
    run_shift(3, 0);
    run_fill(2, 4'b1100);
    run_shift(2, 0);

    // Fill and shift kick together in READY: fill accepted, shift flagged.
    sc_fill_kick = 1'b1; sc_shift_kick = 1'b1; cfg_fill_len = 5'd2; cfg_ch_mask = 4'b1100;
    cur_mask = 4'b1100;
    @(negedge clk);
    sc_fill_kick = 1'b0; sc_shift_kick = 1'b0;
    #1;
    chk("both_kick_en", 32'(fm_shift_enable), 32'hc);
    chk("both_kick_err", 32'(sc_kick_err), 32'h1);
    @(negedge clk);
    #1 chk("both_kick_en2", 32'(fm_shift_enable), 32'hc);
    @(negedge clk);
    #1 chk("both_kick_fdone", 32'(sc_fill_done), 32'h1);
    run_shift(1, 0);

    // Randomized sequences.
    for (int k = 0; k < 10; k++) begin
      run_fill($urandom_range(0, 31), 4'($urandom_range(0, 15)));
      run_shift($urandom_range(0, 40), $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
